indication_output_queue: RTL and testbench

- Parametrised successor to the two-slot, ping-pong indication serializer.
- Accepts up to NUM_METHODS indication method calls and tags each with its method number. Buffers the tagged messages in a DEPTH-entry FIFO and drives them onto the pipe$enq ENA/RDY output in acceptance order.
- Sits between the user indication interface and the transport pipe. It replaces the fixed two-register busy/even scheme with a real queue, so back-to-back indications no longer stall for a cycle.

---
 rtl/indication_output_queue.sv | 98 +++++++++
 tb/tb_indication_output_queue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/indication_output_queue.sv
// Indication serializer: tags per-method calls with method number + 1 and
// queues them in a DEPTH-entry FIFO driving the pipe_enq ENA/RDY output.
module indication_output_queue #(
   parameter int NUM_METHODS = 2,
   parameter int DATA_W      = 64,
   parameter int TAG_W       = 32,
   parameter int DEPTH       = 4
) (
   input  logic                          CLK,
   input  logic                          nRST,
   input  logic [NUM_METHODS-1:0]        indication__ENA,
   input  logic [NUM_METHODS*DATA_W-1:0] indication_v,
   output logic [NUM_METHODS-1:0]        indication__RDY,
   input  logic                          flush__ENA,
   output logic                          flush__RDY,
   output logic                          pipe_enq__ENA,
   output logic [TAG_W+DATA_W-1:0]       pipe_enq_v,
   input  logic                          pipe_enq__RDY,
   output logic [$clog2(DEPTH):0]        count,
   output logic                          overflow_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int MW = TAG_W + DATA_W;

   logic [MW-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [MW-1:0] entry;
   logic          full;
   logic          any;
   logic          multi;
   logic          acc;
   logic          pop;
   logic          err_set;
   int            sel;
   int            hits;

   // Lowest-index enable wins; the hit count flags caller contract violations.
   always_comb begin
      sel  = 0;
      hits = 0;
      for (int i = NUM_METHODS - 1; i >= 0; i--) begin
         if (indication__ENA[i]) begin
            sel  = i;
            hits = hits + 1;
         end
      end
   end

   assign entry   = {indication_v[sel*DATA_W +: DATA_W], TAG_W'(sel + 1)};
   assign full    = (count == CW'(DEPTH));
   assign any     = (hits != 0);
   assign multi   = (hits > 1);
   assign acc     = any & ~full;
   assign pop     = pipe_enq__ENA & pipe_enq__RDY;
   assign err_set = multi | (any & full);

   assign indication__RDY = {NUM_METHODS{nRST & ~full}};
   assign flush__RDY      = nRST;
   assign pipe_enq__ENA   = nRST & (count != '0);
   assign pipe_enq_v      = mem[rd_ptr];

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         overflow_err <= 1'b0;
      end else begin
         if (err_set)
            overflow_err <= 1'b1;
         if (flush__ENA) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (acc)
               wr_ptr <= wr_ptr + 1'b1;
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
            case ({acc, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: ;
            endcase
         end
      end
   end

   // Storage is not reset; count qualifies which entries are live.
   always_ff @(posedge CLK) begin
      if (nRST && acc && !flush__ENA)
         mem[wr_ptr] <= entry;
   end

endmodule

// File: tb/tb_indication_output_queue.sv
// Bench for indication_output_queue: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_indication_output_queue;

   localparam int NM = 2;
   localparam int DW = 64;
   localparam int TW = 32;
   localparam int DP = 4;

   logic           clk;
   logic           rst_n;
   logic [NM-1:0]  ena;
   logic [NM*DW-1:0] vv;
   logic [NM-1:0]  rdy;
   logic           flush;
   logic           flush_rdy;
   logic           pena;
   logic [TW+DW-1:0] pv;
   logic           prdy;
   logic [2:0]     cnt;
   logic           err;

   int checks;
   int errors;

   logic [TW+DW-1:0] q[$];
   bit               merr;

   indication_output_queue #(
      .NUM_METHODS(NM), .DATA_W(DW), .TAG_W(TW), .DEPTH(DP)
   ) dut (
      .CLK(clk),
      .nRST(rst_n),
      .indication__ENA(ena),
      .indication_v(vv),
      .indication__RDY(rdy),
      .flush__ENA(flush),
      .flush__RDY(flush_rdy),
      .pipe_enq__ENA(pena),
      .pipe_enq_v(pv),
      .pipe_enq__RDY(prdy),
      .count(cnt),
      .overflow_err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference model: one transaction step from the rules, using a queue.
   task automatic model_step(input logic [1:0] e, input logic [127:0] v,
                             input logic f, input logic r, input logic rn);
      bit          full;
      bit          any;
      logic [63:0] pay;
      int          idx;
      if (!rn) begin
         q.delete();
         merr = 0;
         return;
      end
      full = (q.size() == DP);
      any  = (e != 2'b00);
      if (e == 2'b11 || (any && full))
         merr = 1;
      idx = e[0] ? 0 : 1;
      pay = idx == 0 ? v[63:0] : v[127:64];
      if (f) begin
         q.delete();
      end else begin
         if (r && q.size() != 0)
            void'(q.pop_front());
         if (any && !full)
            q.push_back({pay, 32'(idx + 1)});
      end
   endtask

   task automatic cyc(input logic [1:0] e, input logic [127:0] v,
                      input logic f, input logic r);
      ena   = e;
      vv    = v;
      flush = f;
      prdy  = r;
      @(posedge clk);
      model_step(e, v, f, r, rst_n);
      @(negedge clk);
      ena   = '0;
      flush = 1'b0;
      prdy  = 1'b0;
   endtask

   task automatic chk_model(input string tag);
      check({tag, "_count"}, 128'(cnt), 128'(q.size()));
      check({tag, "_rdy"}, 128'(rdy), q.size() < DP ? 128'd3 : 128'd0);
      check({tag, "_pena"}, 128'(pena), 128'(q.size() != 0));
      check({tag, "_err"}, 128'(err), 128'(merr));
      if (q.size() != 0)
         check({tag, "_head"}, 128'(pv), 128'(q[0]));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ena   = '0;
      flush = 1'b0;
      prdy  = 1'b0;
      repeat (2) @(posedge clk);
      model_step(2'b00, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("rst_rdy", 128'(rdy), 128'd0);
      check("rst_flush_rdy", 128'(flush_rdy), 128'd0);
      check("rst_pena", 128'(pena), 128'd0);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rel_rdy", 128'(rdy), 128'd3);
      check("rel_pena", 128'(pena), 128'd0);
      check("rel_count", 128'(cnt), 128'd0);
      check("rel_err", 128'(err), 128'd0);
      check("rel_flush_rdy", 128'(flush_rdy), 128'd1);
   endtask

   typedef struct {
      logic [1:0]  e;
      logic [63:0] pay;
      logic        r;
      logic [2:0]  x_cnt;
      logic [1:0]  x_rdy;
      logic        x_pena;
      logic [31:0] x_tag;
      logic [63:0] x_pay;
   } vec_t;

   vec_t tbl[8];

   function automatic logic [127:0] place(input logic [1:0] e,
                                          input logic [63:0] p);
      return e[0] ? {64'h0, p} : {p, 64'h0};
   endfunction

   initial begin
      logic [127:0] rv;
      logic [1:0]   re;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      ena    = '0;
      vv     = '0;
      flush  = 1'b0;
      prdy   = 1'b0;
      merr   = 0;

      // Fill-then-drain table; expectations are the state after each row.
      tbl[0] = '{2'b01, 64'hF0, 1'b0, 3'd1, 2'b11, 1'b1, 32'd1, 64'hF0};
      tbl[1] = '{2'b10, 64'hF1, 1'b0, 3'd2, 2'b11, 1'b1, 32'd1, 64'hF0};
      tbl[2] = '{2'b01, 64'hF2, 1'b0, 3'd3, 2'b11, 1'b1, 32'd1, 64'hF0};
      tbl[3] = '{2'b10, 64'hF3, 1'b0, 3'd4, 2'b00, 1'b1, 32'd1, 64'hF0};
      tbl[4] = '{2'b00, 64'h0,  1'b1, 3'd3, 2'b11, 1'b1, 32'd2, 64'hF1};
      tbl[5] = '{2'b00, 64'h0,  1'b1, 3'd2, 2'b11, 1'b1, 32'd1, 64'hF2};
      tbl[6] = '{2'b00, 64'h0,  1'b1, 3'd1, 2'b11, 1'b1, 32'd2, 64'hF3};
      tbl[7] = '{2'b00, 64'h0,  1'b1, 3'd0, 2'b11, 1'b0, 32'd0, 64'h0};

      @(negedge clk);
      do_reset();

      // Single message
      cyc(2'b10, {64'h0000_0005_0000_0007, 64'h0}, 1'b0, 1'b1);
      check("single_pena", 128'(pena), 128'd1);
      check("single_tag", 128'(pv[31:0]), 128'd2);
      check("single_pay", 128'(pv[95:32]), 128'h0000_0005_0000_0007);
      check("single_cnt1", 128'(cnt), 128'd1);
      cyc(2'b00, '0, 1'b0, 1'b1);
      check("single_cnt0", 128'(cnt), 128'd0);
      check("single_pena0", 128'(pena), 128'd0);

      for (int i = 0; i < 8; i++) begin
         cyc(tbl[i].e, place(tbl[i].e, tbl[i].pay), 1'b0, tbl[i].r);
         check($sformatf("tbl%0d_cnt", i), 128'(cnt), 128'(tbl[i].x_cnt));
         check($sformatf("tbl%0d_rdy", i), 128'(rdy), 128'(tbl[i].x_rdy));
         check($sformatf("tbl%0d_pena", i), 128'(pena),
               128'(tbl[i].x_pena));
         if (tbl[i].x_pena) begin
            check($sformatf("tbl%0d_tag", i), 128'(pv[31:0]),
                  128'(tbl[i].x_tag));
            check($sformatf("tbl%0d_pay", i), 128'(pv[95:32]),
                  128'(tbl[i].x_pay));
         end
      end

      // Simultaneous push/pop at count=2, then full with pop+ENA
      cyc(2'b01, place(2'b01, 64'hB0), 1'b0, 1'b0);
      cyc(2'b10, place(2'b10, 64'hB1), 1'b0, 1'b0);
      cyc(2'b01, place(2'b01, 64'hB2), 1'b0, 1'b1);
      check("pp_cnt", 128'(cnt), 128'd2);
      check("pp_head", 128'(pv), {32'h0, 64'hB1, 32'd2});
      cyc(2'b10, place(2'b10, 64'hB3), 1'b0, 1'b0);
      cyc(2'b01, place(2'b01, 64'hB4), 1'b0, 1'b0);
      check("full_cnt", 128'(cnt), 128'd4);
      check("full_err0", 128'(err), 128'd0);
      cyc(2'b10, place(2'b10, 64'hB5), 1'b0, 1'b1);
      check("fullpop_cnt", 128'(cnt), 128'd3);
      check("fullpop_err", 128'(err), 128'd1);
      check("fullpop_rdy", 128'(rdy), 128'd3);
      check("drain_b2", 128'(pv), {32'h0, 64'hB2, 32'd1});
      cyc(2'b00, '0, 1'b0, 1'b1);
      check("drain_b3", 128'(pv), {32'h0, 64'hB3, 32'd2});
      cyc(2'b00, '0, 1'b0, 1'b1);
      check("drain_b4", 128'(pv), {32'h0, 64'hB4, 32'd1});
      cyc(2'b00, '0, 1'b0, 1'b1);
      check("drain_empty", 128'(cnt), 128'd0);

      // Mid-operation reset drops queued messages
      cyc(2'b01, place(2'b01, 64'hE0), 1'b0, 1'b0);
      cyc(2'b10, place(2'b10, 64'hE1), 1'b0, 1'b0);
      do_reset();

      // Contract violation: two ENAs at once
      cyc(2'b11, {64'hC1, 64'hC0}, 1'b0, 1'b0);
      check("multi_cnt", 128'(cnt), 128'd1);
      check("multi_head", 128'(pv), {32'h0, 64'hC0, 32'd1});
      check("multi_err", 128'(err), 128'd1);
      repeat (10) cyc(2'b00, '0, 1'b0, 1'b0);
      check("multi_err_idle", 128'(err), 128'd1);
      check("multi_cnt_idle", 128'(cnt), 128'd1);
      cyc(2'b00, '0, 1'b1, 1'b0);
      check("multi_err_flush", 128'(err), 128'd1);
      check("flush0_cnt", 128'(cnt), 128'd0);

      // Flush with concurrent accept and transfer
      cyc(2'b01, place(2'b01, 64'hD0), 1'b0, 1'b0);
      cyc(2'b10, place(2'b10, 64'hD1), 1'b0, 1'b0);
      cyc(2'b01, place(2'b01, 64'hD2), 1'b0, 1'b0);
      check("fl_q3", 128'(cnt), 128'd3);
      check("fl_head", 128'(pv), {32'h0, 64'hD0, 32'd1});
      check("fl_head_valid", 128'(pena), 128'd1);
      cyc(2'b01, place(2'b01, 64'hD3), 1'b1, 1'b1);
      check("fl_cnt", 128'(cnt), 128'd0);
      check("fl_pena", 128'(pena), 128'd0);
      cyc(2'b00, '0, 1'b0, 1'b0);
      check("fl_cnt_after", 128'(cnt), 128'd0);
      check("fl_pena_after", 128'(pena), 128'd0);

      // Randomized traffic against the queue model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         rv = {$urandom, $urandom, $urandom, $urandom};
         case ($urandom_range(0, 9))
            0, 1, 2: re = 2'b00;
            3, 4, 5: re = 2'b01;
            6, 7, 8: re = 2'b10;
            default: re = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'b01;
         endcase
         cyc(re, rv, $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
         chk_model("rnd");
         if (n == 1500)
            do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule
